// File: rtl/noc_router_pkg.sv
`default_nettype none
// ============================================================================
// noc_router_pkg : port indices, header fields and XY routing for the router
// Rev 1.0
// ============================================================================
package noc_router_pkg;

  typedef enum logic [2:0] {
    P_N = 3'd0,
    P_S = 3'd1,
    P_E = 3'd2,
    P_W = 3'd3,
    P_L = 3'd4
  } port_e;

  localparam int NPORTS = 5;

  localparam int DX_HI = 7;
  localparam int DX_LO = 4;
  localparam int DY_HI = 3;
  localparam int DY_LO = 0;

  // Dimension-ordered routing: resolve X completely before moving in Y.
  function automatic port_e route_xy(input logic [3:0] dx, input logic [3:0] dy,
                                     input logic [3:0] x, input logic [3:0] y);
    port_e r;
    if (dx > x)      r = P_E;
    else if (dx < x) r = P_W;
    else if (dy > y) r = P_N;
    else if (dy < y) r = P_S;
    else             r = P_L;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/noc_in_fifo.sv
`default_nettype none
// ============================================================================
// noc_in_fifo : per-input flit buffer with first-word-fall-through head
// Rev 1.0
// ============================================================================
module noc_in_fifo
  import noc_router_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_rd,
  output logic              o_full,
  output logic              o_empty,
  output logic [DATA_W-1:0] o_head
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;
  localparam logic [CNTW-1:0] c_full = DEPTH[CNTW-1:0];

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wp;
  logic [AW-1:0]     r_rp;
  logic [CNTW-1:0]   r_cnt;
  logic              w_wr;
  logic              w_rd;

  assign o_full  = (r_cnt == c_full);
  assign o_empty = (r_cnt == '0);
  assign o_head  = r_mem[r_rp];

  // A full FIFO still takes a write when its head leaves in the same cycle.
  assign w_rd = i_rd & ~o_empty;
  assign w_wr = i_wr & (~o_full | w_rd);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + AW'(1);
      if (w_rd) r_rp <= r_rp + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + CNTW'(1);
        2'b01:   r_cnt <= r_cnt - CNTW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp] <= i_wdata;
  end

endmodule
`default_nettype wire

// File: rtl/noc_mesh_router.sv
`default_nettype none
// ============================================================================
// noc_mesh_router : 5-port XY mesh router, credit flow control, RR arbiters
// Rev 1.0
// ============================================================================
module noc_mesh_router
  import noc_router_pkg::*;
#(
  parameter int                 XCOORD    = 0,
  parameter int                 YCOORD    = 0,
  parameter int                 DATA_W    = 16,
  parameter int                 DEPTH     = 4,
  parameter logic [NPORTS-1:0]  PORT_MASK = 5'b11111
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NPORTS-1:0][DATA_W-1:0]  in_data,
  input  logic [NPORTS-1:0]              in_valid,
  output logic [NPORTS-1:0]              in_credit,
  output logic [NPORTS-1:0][DATA_W-1:0]  out_data,
  output logic [NPORTS-1:0]              out_valid,
  input  logic [NPORTS-1:0]              out_credit,
  output logic                           drop,
  output logic                           overflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] c_depth = DEPTH[CW-1:0];
  localparam logic [3:0]    c_x     = XCOORD[3:0];
  localparam logic [3:0]    c_y     = YCOORD[3:0];

  logic [NPORTS-1:0]              w_full;
  logic [NPORTS-1:0]              w_empty;
  logic [NPORTS-1:0][DATA_W-1:0]  w_head;
  logic [NPORTS-1:0][2:0]         w_route;
  logic [NPORTS-1:0]              w_bad;
  logic [NPORTS-1:0]              w_pop;
  logic [NPORTS-1:0][NPORTS-1:0]  w_req;   // [output][input]
  logic [NPORTS-1:0][NPORTS-1:0]  w_gnt;   // [output][input]
  logic [NPORTS-1:0]              w_send;
  logic [NPORTS-1:0][DATA_W-1:0]  w_odata;

  logic [NPORTS-1:0][CW-1:0]      r_credit;
  logic [NPORTS-1:0][2:0]         r_ptr;

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    if (PORT_MASK[p]) begin : g_fifo
      noc_in_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
      ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_wr    (in_valid[p]),
        .i_wdata (in_data[p]),
        .i_rd    (w_pop[p]),
        .o_full  (w_full[p]),
        .o_empty (w_empty[p]),
        .o_head  (w_head[p])
      );
    end else begin : g_absent
      assign w_full[p]  = 1'b0;
      assign w_empty[p] = 1'b1;
      assign w_head[p]  = '0;
    end

    assign w_route[p] = route_xy(w_head[p][DX_HI:DX_LO], w_head[p][DY_HI:DY_LO], c_x, c_y);
    // Heads bound for a missing port or back where they came from are flushed.
    assign w_bad[p]   = ~w_empty[p] & (~PORT_MASK[w_route[p]] | (w_route[p] == 3'(p)));
  end

  always_comb begin
    w_req = '0;
    for (int o = 0; o < NPORTS; o++) begin
      for (int i = 0; i < NPORTS; i++) begin
        w_req[o][i] = PORT_MASK[o] & ~w_empty[i] & ~w_bad[i] &
                      (w_route[i] == 3'(o)) & (r_credit[o] != '0);
      end
    end
  end

  // Scanning offsets high-to-low leaves the requester nearest the pointer granted.
  always_comb begin : p_arb
    logic [3:0] sum;
    logic [2:0] idx;
    w_gnt = '0;
    sum   = '0;
    idx   = '0;
    for (int o = 0; o < NPORTS; o++) begin
      for (int k = NPORTS - 1; k >= 0; k--) begin
        sum = {1'b0, r_ptr[o]} + 4'(k);
        if (sum >= 4'(NPORTS)) sum = sum - 4'(NPORTS);
        idx = sum[2:0];
        if (w_req[o][idx]) begin
          w_gnt[o]      = '0;
          w_gnt[o][idx] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_odata = '0;
    w_pop   = w_bad;
    w_send  = '0;
    for (int o = 0; o < NPORTS; o++) begin
      w_send[o] = |w_gnt[o];
      for (int i = 0; i < NPORTS; i++) begin
        if (w_gnt[o][i]) begin
          w_odata[o] = w_head[i];
          w_pop[i]   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= '0;
      out_data  <= '0;
      in_credit <= '0;
      drop      <= 1'b0;
      overflow  <= 1'b0;
      for (int o = 0; o < NPORTS; o++) begin
        r_credit[o] <= c_depth;
        r_ptr[o]    <= '0;
      end
    end else begin
      out_valid <= w_send;
      out_data  <= w_odata;
      in_credit <= w_pop & PORT_MASK;
      drop      <= |w_bad;
      if (|(in_valid & PORT_MASK & w_full & ~w_pop)) overflow <= 1'b1;
      for (int o = 0; o < NPORTS; o++) begin
        if (PORT_MASK[o]) begin
          if (w_send[o] & ~out_credit[o])
            r_credit[o] <= r_credit[o] - CW'(1);
          else if (out_credit[o] & ~w_send[o] & (r_credit[o] != c_depth))
            r_credit[o] <= r_credit[o] + CW'(1);
        end
        for (int i = 0; i < NPORTS; i++) begin
          if (w_gnt[o][i]) r_ptr[o] <= (i == NPORTS - 1) ? 3'd0 : 3'(i + 1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_noc_mesh_router.sv
`default_nettype none
// ============================================================================
// tb_noc_mesh_router : directed and randomized checks against a queue model
// Rev 1.0
// ============================================================================
module tb_noc_mesh_router;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int X     = 1;
  localparam int Y     = 1;
  localparam int PN = 0, PS = 1, PE = 2, PW = 3, PL = 4;
  localparam logic [4:0] MASK = 5'b11111;

  logic clk = 1'b0;
  logic rst;
  logic [4:0][DW-1:0] in_data, out_data, b_in_data, b_out_data;
  logic [4:0] in_valid, in_credit, out_valid, out_credit;
  logic [4:0] b_in_valid, b_in_credit, b_out_valid, b_out_credit;
  logic drop, overflow, b_drop, b_overflow;

  always #5 clk = ~clk;

  noc_mesh_router #(.XCOORD(X), .YCOORD(Y), .DATA_W(DW), .DEPTH(DEPTH), .PORT_MASK(MASK)) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_credit(in_credit),
    .out_data(out_data), .out_valid(out_valid), .out_credit(out_credit),
    .drop(drop), .overflow(overflow));

  noc_mesh_router #(.XCOORD(X), .YCOORD(Y), .DATA_W(DW), .DEPTH(DEPTH), .PORT_MASK(5'b10101)) u_dut_b (
    .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid), .in_credit(b_in_credit),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_credit(b_out_credit),
    .drop(b_drop), .overflow(b_overflow));

  int n_total = 0, n_pass = 0, n_fail = 0;
  logic echo;

  logic [DW-1:0] mq [5][$];
  int mcred [5];
  int mptr  [5];
  logic [4:0] e_ov, e_ic;
  logic [4:0][DW-1:0] e_od;
  logic e_drop, e_ovf;

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int route(input logic [DW-1:0] f);
    int dx, dy;
    dx = int'(f[7:4]);
    dy = int'(f[3:0]);
    if (dx > X) return PE;
    if (dx < X) return PW;
    if (dy > Y) return PN;
    if (dy < Y) return PS;
    return PL;
  endfunction

  // Advance the model by one cycle using the inputs currently driven.
  task automatic model_step();
    logic [4:0] pop;
    int d;
    e_ov = '0; e_od = '0; e_ic = '0; e_drop = 1'b0;
    if (rst) begin
      for (int p = 0; p < 5; p++) begin
        mq[p].delete();
        mcred[p] = DEPTH;
        mptr[p]  = 0;
      end
      e_ovf = 1'b0;
      return;
    end
    pop = '0;
    for (int i = 0; i < 5; i++) begin
      if (mq[i].size() > 0) begin
        d = route(mq[i][0]);
        if (!MASK[d] || d == i) begin pop[i] = 1'b1; e_drop = 1'b1; end
      end
    end
    for (int o = 0; o < 5; o++) begin
      if (MASK[o] && mcred[o] > 0) begin
        for (int k = 0; k < 5; k++) begin
          int i;
          i = (mptr[o] + k) % 5;
          if (mq[i].size() > 0 && !pop[i] && route(mq[i][0]) == o) begin
            e_ov[o] = 1'b1;
            e_od[o] = mq[i][0];
            pop[i]  = 1'b1;
            mptr[o] = (i + 1) % 5;
            break;
          end
        end
      end
    end
    for (int o = 0; o < 5; o++) begin
      if (e_ov[o] && !out_credit[o]) mcred[o]--;
      else if (out_credit[o] && !e_ov[o] && mcred[o] < DEPTH) mcred[o]++;
    end
    e_ic = pop;
    for (int i = 0; i < 5; i++) if (pop[i]) void'(mq[i].pop_front());
    for (int i = 0; i < 5; i++) begin
      if (in_valid[i] && MASK[i]) begin
        if (mq[i].size() < DEPTH) mq[i].push_back(in_data[i]);
        else e_ovf = 1'b1;
      end
    end
  endtask

  task automatic tick();
    if (echo) out_credit = out_valid;
    model_step();
    @(posedge clk);
    #1;
    chk("model_out_valid", 80'(out_valid), 80'(e_ov));
    chk("model_out_data",  80'(out_data),  80'(e_od));
    chk("model_in_credit", 80'(in_credit), 80'(e_ic));
    chk("model_drop",      80'(drop),      80'(e_drop));
    chk("model_overflow",  80'(overflow),  80'(e_ovf));
  endtask

  initial begin
    int ecount;
    logic [DW-1:0] got_q [$];
    rst = 1'b1; echo = 1'b0;
    in_valid = '0; in_data = '0; out_credit = '0;
    b_in_valid = '0; b_in_data = '0; b_out_credit = '0;
    tick(); tick();
    chk("reset_out_valid", 80'(out_valid), 80'(0));
    chk("reset_out_data",  80'(out_data),  80'(0));
    chk("reset_in_credit", 80'(in_credit), 80'(0));
    chk("reset_overflow",  80'(overflow),  80'(0));
    rst = 1'b0;

    // Two-cycle latency east, and a drop toward the missing W port on the corner router.
    in_valid[PL] = 1'b1; in_data[PL] = 16'h0021;
    b_in_valid[PL] = 1'b1; b_in_data[PL] = 16'h0001;
    tick();
    in_valid = '0; b_in_valid = '0;
    chk("lat_c1_valid", 80'(out_valid), 80'(0));
    chk("b_c1_drop", 80'(b_drop), 80'(0));
    tick();
    chk("lat_c2_valid",  80'(out_valid),  80'(5'b00100));
    chk("lat_c2_data",   80'(out_data[PE]), 80'(16'h0021));
    chk("lat_c2_credit", 80'(in_credit),  80'(5'b10000));
    chk("b_drop_pulse",  80'(b_drop),      80'(1));
    chk("b_drop_credit", 80'(b_in_credit), 80'(5'b10000));
    chk("b_drop_nosend", 80'(b_out_valid), 80'(0));
    tick();
    chk("lat_c3_valid", 80'(out_valid), 80'(0));
    chk("b_c3_drop",    80'(b_drop),    80'(0));

    // N and W compete for L; grants alternate starting at N.
    echo = 1'b1;
    in_valid[PN] = 1'b1; in_data[PN] = 16'hA011;
    in_valid[PW] = 1'b1; in_data[PW] = 16'hB011;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k >= 2) begin
        chk("rr_valid", 80'(out_valid[PL]), 80'(1));
        chk("rr_data",  80'(out_data[PL]),  80'((k % 2 == 0) ? 16'hA011 : 16'hB011));
      end
    end
    in_valid = '0;
    for (int k = 0; k < 12; k++) tick();
    echo = 1'b0; out_credit = '0;
    rst = 1'b1; tick(); rst = 1'b0;

    // Credit exhaustion toward E.
    ecount = 0;
    for (int f = 0; f < DEPTH + 1; f++) begin
      in_valid[PL] = 1'b1; in_data[PL] = {8'(f + 1), 8'h21};
      tick();
      if (out_valid[PE]) ecount++;
    end
    in_valid = '0;
    for (int k = 0; k < 8; k++) begin tick(); if (out_valid[PE]) ecount++; end
    chk("credit_block_sends", 80'(ecount), 80'(DEPTH));
    out_credit[PE] = 1'b1; tick(); out_credit = '0;
    chk("credit_release_c1", 80'(out_valid[PE]), 80'(0));
    tick();
    chk("credit_release_c2", 80'(out_valid[PE]), 80'(1));
    chk("credit_release_data", 80'(out_data[PE]), 80'({8'(DEPTH + 1), 8'h21}));

    // Overflow on N while E has no credit; FIFO keeps the first DEPTH flits.
    for (int f = 0; f < DEPTH + 1; f++) begin
      if (f == DEPTH) chk("ovf_before", 80'(overflow), 80'(0));
      in_valid[PN] = 1'b1; in_data[PN] = {8'(8'hC0 + f), 8'h21};
      tick();
    end
    in_valid = '0;
    chk("ovf_set", 80'(overflow), 80'(1));
    for (int k = 0; k < 8; k++) begin
      out_credit[PE] = (k < DEPTH);
      tick();
      if (out_valid[PE]) got_q.push_back(out_data[PE]);
    end
    out_credit = '0;
    chk("ovf_drain_count", 80'(got_q.size()), 80'(DEPTH));
    for (int f = 0; f < DEPTH; f++)
      chk("ovf_order", 80'((got_q.size() > f) ? got_q[f] : 16'hxxxx), 80'({8'(8'hC0 + f), 8'h21}));

    // Reset mid-stream with N full and a write in progress.
    for (int f = 0; f < DEPTH; f++) begin
      in_valid[PN] = 1'b1; in_data[PN] = {8'(8'hE0 + f), 8'h21};
      tick();
    end
    rst = 1'b1; tick(); rst = 1'b0; in_valid = '0;
    chk("rst_mid_valid",    80'(out_valid), 80'(0));
    chk("rst_mid_data",     80'(out_data),  80'(0));
    chk("rst_mid_incredit", 80'(in_credit), 80'(0));
    chk("rst_mid_drop",     80'(drop),      80'(0));
    chk("rst_mid_overflow", 80'(overflow),  80'(0));
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_no_credit", 80'(in_credit), 80'(0));
    end
    ecount = 0;
    for (int f = 0; f < DEPTH; f++) begin
      in_valid[PL] = 1'b1; in_data[PL] = {8'(8'hD0 + f), 8'h21};
      tick();
      if (out_valid[PE]) ecount++;
    end
    in_valid = '0;
    for (int k = 0; k < 6; k++) begin tick(); if (out_valid[PE]) ecount++; end
    chk("rst_credit_depth", 80'(ecount), 80'(DEPTH));

    // Randomized traffic, including U-turns and a reset pulse.
    for (int c = 0; c < 400; c++) begin
      rst = (c == 200);
      in_valid = 5'($urandom);
      for (int p = 0; p < 5; p++)
        in_data[p] = {8'($urandom), 4'($urandom_range(0, 2)), 4'($urandom_range(0, 2))};
      out_credit = 5'($urandom);
      tick();
    end
    rst = 1'b0; in_valid = '0; out_credit = 5'h1f;
    for (int k = 0; k < 20; k++) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
